// File: rtl/piezo_decode_pkg.sv
// Shared types and constants for the piezo tone decoder: note/tune encodings,
// nominal note periods, the reference tune sequences and the tune matcher.
package piezo_pkg;

    typedef enum logic [1:0] {G6 = 2'd0, C7 = 2'd1, E7 = 2'd2, G7 = 2'd3} note_t;
    typedef enum logic [1:0] {UNKNOWN = 2'd0, STEER = 2'd1, FAST = 2'd2, BATT = 2'd3} tune_t;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FIRST = 2'd1, ST_TONE = 2'd2} dec_state_t;

    localparam int G6_PER_NOM = 31888;
    localparam int C7_PER_NOM = 23889;
    localparam int E7_PER_NOM = 18961;
    localparam int G7_PER_NOM = 15944;
    localparam int FAST_DIV   = 1000;

    // Tune buffer: entry 0 is the first note heard.
    typedef logic [5:0][1:0] tune_buf_t;
    localparam logic [2:0] TUNE_MAX = 3'd6;

    localparam tune_buf_t        STEER_SEQ = {G7, E7, G7, E7, C7, G6};
    localparam tune_buf_t        BATT_SEQ  = {G6, C7, E7, G7, E7, G7};
    localparam logic [2:0][1:0]  FAST_SEQ  = {E7, C7, G6};

    function automatic int per_tol(input int nom);
        int t;
        t = nom / 16;
        return (t > 1) ? t : 1;
    endfunction

    function automatic tune_t tune_match(input tune_buf_t seq, input logic [2:0] cnt,
                                         input logic ovf);
        tune_t res;
        res = UNKNOWN;
        if (ovf) begin
            res = UNKNOWN;
        end else if ((cnt == 3'd3) && (seq[2:0] == FAST_SEQ)) begin
            res = FAST;
        end else if ((cnt == 3'd6) && (seq == STEER_SEQ)) begin
            res = STEER;
        end else if ((cnt == 3'd6) && (seq == BATT_SEQ)) begin
            res = BATT;
        end else begin
            res = UNKNOWN;
        end
        return res;
    endfunction

endpackage

// File: rtl/piezo_decode_if.sv
// Result bus of the piezo tone decoder towards the test harness / status logic.
interface piezo_decode_if;
    logic        note_vld;
    logic [1:0]  note_id;
    logic [25:0] note_len;
    logic        tune_vld;
    logic [1:0]  tune_id;
    logic        bad_per;

    modport master (output note_vld, note_id, note_len, tune_vld, tune_id, bad_per);
    modport slave  (input  note_vld, note_id, note_len, tune_vld, tune_id, bad_per);
endinterface

// File: rtl/piezo_per_meas.sv
// Period front end: synchronizes piezo, measures rise-to-rise periods,
// classifies them against the note windows and flags silence.
module piezo_per_meas
    import piezo_pkg::*;
#(
    parameter int G6_PER  = G6_PER_NOM,
    parameter int C7_PER  = C7_PER_NOM,
    parameter int E7_PER  = E7_PER_NOM,
    parameter int G7_PER  = G7_PER_NOM,
    parameter int SIL_LEN = 2 * G6_PER_NOM
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        piezo,
    output logic        per_vld,
    output note_t       per_note,
    output logic        per_unk,
    output logic [15:0] per_cnt,
    output logic        silence
);

    localparam logic [15:0] G6_LO = 16'(G6_PER - per_tol(G6_PER));
    localparam logic [15:0] G6_HI = 16'(G6_PER + per_tol(G6_PER));
    localparam logic [15:0] C7_LO = 16'(C7_PER - per_tol(C7_PER));
    localparam logic [15:0] C7_HI = 16'(C7_PER + per_tol(C7_PER));
    localparam logic [15:0] E7_LO = 16'(E7_PER - per_tol(E7_PER));
    localparam logic [15:0] E7_HI = 16'(E7_PER + per_tol(E7_PER));
    localparam logic [15:0] G7_LO = 16'(G7_PER - per_tol(G7_PER));
    localparam logic [15:0] G7_HI = 16'(G7_PER + per_tol(G7_PER));
    localparam logic [15:0] SIL_CNT = 16'(SIL_LEN);

    logic        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rise_s;

    assign rise_s  = sync2_q & ~prev_q;
    assign per_vld = rise_s;
    assign per_cnt = cnt_q;
    assign silence = ~rise_s & (cnt_q == SIL_CNT);

    // Next-state for synchronizer chain and saturating period counter.
    always_comb begin
        sync1_d = piezo;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        if (rise_s) begin
            cnt_d = 16'd1;
        end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Window classifier; windows are disjoint so the order does not matter.
    always_comb begin
        per_note = G6;
        per_unk  = 1'b0;
        if ((cnt_q >= G6_LO) && (cnt_q <= G6_HI)) begin
            per_note = G6;
        end else if ((cnt_q >= C7_LO) && (cnt_q <= C7_HI)) begin
            per_note = C7;
        end else if ((cnt_q >= E7_LO) && (cnt_q <= E7_HI)) begin
            per_note = E7;
        end else if ((cnt_q >= G7_LO) && (cnt_q <= G7_HI)) begin
            per_note = G7;
        end else begin
            per_unk = 1'b1;
        end
    end

    // Front-end registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/piezo_decode.sv
// Piezo tone decoder top: groups classified periods into notes, reports each
// note with its length and matches the note sequence against known tunes at silence.
module piezo_decode
    import piezo_pkg::*;
#(
    parameter bit fast_sim = 1'b0,
    parameter int G6_PER   = fast_sim ? (G6_PER_NOM / FAST_DIV) : G6_PER_NOM,
    parameter int C7_PER   = fast_sim ? (C7_PER_NOM / FAST_DIV) : C7_PER_NOM,
    parameter int E7_PER   = fast_sim ? (E7_PER_NOM / FAST_DIV) : E7_PER_NOM,
    parameter int G7_PER   = fast_sim ? (G7_PER_NOM / FAST_DIV) : G7_PER_NOM,
    parameter int SIL_LEN  = 2 * G6_PER
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           piezo,
    piezo_decode_if.master bus
);

    localparam logic [25:0] LEN_MAX = {26{1'b1}};

    logic        per_vld_s, per_unk_s, silence_s;
    note_t       per_note_s;
    logic [15:0] per_cnt_s;

    piezo_per_meas #(
        .G6_PER (G6_PER), .C7_PER (C7_PER), .E7_PER (E7_PER),
        .G7_PER (G7_PER), .SIL_LEN(SIL_LEN)
    ) u_meas (
        .clk(clk), .rst_n(rst_n), .piezo(piezo),
        .per_vld(per_vld_s), .per_note(per_note_s), .per_unk(per_unk_s),
        .per_cnt(per_cnt_s), .silence(silence_s)
    );

    dec_state_t  state_q, state_d;
    note_t       cur_note_q, cur_note_d, note_id_q, note_id_d;
    logic [25:0] acc_q, acc_d, note_len_q, note_len_d, acc_add_s;
    logic [26:0] sum_s;
    tune_buf_t   buf_q, buf_d;
    logic [2:0]  buf_cnt_q, buf_cnt_d;
    logic        ovf_q, ovf_d, eval_q, eval_d, emit_s;
    logic        note_vld_q, note_vld_d, tune_vld_q, tune_vld_d, bad_per_q, bad_per_d;
    tune_t       tune_id_q, tune_id_d;

    assign sum_s     = {1'b0, acc_q} + {11'd0, per_cnt_s};
    assign acc_add_s = sum_s[26] ? LEN_MAX : sum_s[25:0];

    // Decoder next state: note grouping, emission into the tune buffer, tune evaluation.
    always_comb begin
        state_d    = state_q;
        cur_note_d = cur_note_q;
        acc_d      = acc_q;
        buf_d      = buf_q;
        buf_cnt_d  = buf_cnt_q;
        ovf_d      = ovf_q;
        eval_d     = 1'b0;
        emit_s     = 1'b0;
        note_vld_d = 1'b0;
        note_id_d  = note_id_q;
        note_len_d = note_len_q;
        tune_vld_d = 1'b0;
        tune_id_d  = tune_id_q;
        bad_per_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (per_vld_s) state_d = ST_FIRST;
                else           state_d = ST_IDLE;
            end
            ST_FIRST: begin
                if (silence_s) begin
                    state_d = ST_IDLE;
                    eval_d  = 1'b1;
                end else if (per_vld_s && per_unk_s) begin
                    bad_per_d = 1'b1;
                end else if (per_vld_s) begin
                    state_d    = ST_TONE;
                    cur_note_d = per_note_s;
                    acc_d      = {10'd0, per_cnt_s};
                end else begin
                    state_d = ST_FIRST;
                end
            end
            ST_TONE: begin
                if (silence_s) begin
                    emit_s  = 1'b1;
                    state_d = ST_IDLE;
                    eval_d  = 1'b1;
                end else if (per_vld_s && per_unk_s) begin
                    emit_s    = 1'b1;
                    bad_per_d = 1'b1;
                    state_d   = ST_FIRST;
                end else if (per_vld_s && (per_note_s == cur_note_q)) begin
                    acc_d = acc_add_s;
                end else if (per_vld_s) begin
                    // The closing edge of the old note opens the new one: no cycle lost.
                    emit_s     = 1'b1;
                    cur_note_d = per_note_s;
                    acc_d      = {10'd0, per_cnt_s};
                end else begin
                    state_d = ST_TONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (emit_s) begin
            note_vld_d = 1'b1;
            note_id_d  = cur_note_q;
            note_len_d = acc_q;
            if (buf_cnt_q < TUNE_MAX) begin
                buf_d[buf_cnt_q] = cur_note_q;
                buf_cnt_d        = buf_cnt_q + 3'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            note_vld_d = 1'b0;
        end

        if (eval_q) begin
            if ((buf_cnt_q != 3'd0) || ovf_q) begin
                tune_vld_d = 1'b1;
                tune_id_d  = tune_match(buf_q, buf_cnt_q, ovf_q);
            end else begin
                tune_vld_d = 1'b0;
            end
            buf_cnt_d = 3'd0;
            ovf_d     = 1'b0;
        end else begin
            tune_vld_d = 1'b0;
        end
    end

    // Decoder state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_note_q <= G6;
            acc_q      <= 26'd0;
            buf_q      <= 12'd0;
            buf_cnt_q  <= 3'd0;
            ovf_q      <= 1'b0;
            eval_q     <= 1'b0;
            note_vld_q <= 1'b0;
            note_id_q  <= G6;
            note_len_q <= 26'd0;
            tune_vld_q <= 1'b0;
            tune_id_q  <= UNKNOWN;
            bad_per_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_note_q <= cur_note_d;
            acc_q      <= acc_d;
            buf_q      <= buf_d;
            buf_cnt_q  <= buf_cnt_d;
            ovf_q      <= ovf_d;
            eval_q     <= eval_d;
            note_vld_q <= note_vld_d;
            note_id_q  <= note_id_d;
            note_len_q <= note_len_d;
            tune_vld_q <= tune_vld_d;
            tune_id_q  <= tune_id_d;
            bad_per_q  <= bad_per_d;
        end
    end

    assign bus.note_vld = note_vld_q;
    assign bus.note_id  = note_id_q;
    assign bus.note_len = note_len_q;
    assign bus.tune_vld = tune_vld_q;
    assign bus.tune_id  = tune_id_q;
    assign bus.bad_per  = bad_per_q;

endmodule
